// File: rtl/pitch_fx_sequencer_if.sv
// Change-request channel into the pitch FX sequencer (valid/ready; ratio is 8.8 unsigned).
interface pitch_fx_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_ratio;
  logic        req_enable;

  modport master (output req_valid, req_ratio, req_enable, input req_ready);
  modport slave  (input req_valid, req_ratio, req_enable, output req_ready);
endinterface

// File: rtl/pitch_fx_sequencer.sv
// Drives pitch shifter ratio/enable, muting around enable changes and fading its output samples.
// Build macro PITCH_RAMP_EN: ramp ratio changes in RUN; without it every ratio change runs a full fade.
module pitch_fx_sequencer #(
  parameter logic [15:0] RAMP_STEP = 16'd16,
  parameter int          FADE_LEN  = 256,
  parameter logic [15:0] UNITY     = 16'h0100,
  parameter logic [15:0] MIN_RATIO = 16'h0040,
  parameter logic [15:0] MAX_RATIO = 16'h0400
) (
  input  logic                CLOCK_50,
  input  logic                rst_n,
  input  logic                tick,
  pitch_fx_sequencer_if.slave req,
  output logic                shift_enable,
  output logic [15:0]         pitch_ratio,
  output logic                busy,
  input  logic signed [31:0]  in_L,
  input  logic signed [31:0]  in_R,
  output logic signed [31:0]  out_L,
  output logic signed [31:0]  out_R
);

  localparam logic [16:0] FC_FULL = 17'(FADE_LEN);
  localparam int          GAIN_SH = $clog2(65536 / FADE_LEN);

  typedef enum logic [2:0] {BYPASS, RUN, FADE_OUT, SWITCH, FADE_IN} state_t;

  state_t      state, state_nxt;
  logic [15:0] target, target_nxt, ratio_nxt, clamped;
  logic        pend_en, pend_en_nxt, shift_en_nxt, busy_nxt;
  logic [16:0] fc, fc_nxt, gain;
  logic        accept, fade_req;

  assign req.req_ready = (state == BYPASS) || (state == RUN);
  assign accept        = req.req_valid && req.req_ready;

  assign clamped = (req.req_ratio < MIN_RATIO) ? MIN_RATIO :
                   (req.req_ratio > MAX_RATIO) ? MAX_RATIO : req.req_ratio;

`ifdef PITCH_RAMP_EN
  assign fade_req = (req.req_enable != shift_enable);
`else
  // Without ramping, the only safe way to change the ratio of a running shifter is under mute.
  assign fade_req = (req.req_enable != shift_enable) ||
                    ((state == RUN) && (clamped != pitch_ratio));
  logic [15:0] unused_step;
  assign unused_step = RAMP_STEP;
`endif

  always_comb begin
    state_nxt    = state;
    target_nxt   = target;
    pend_en_nxt  = pend_en;
    shift_en_nxt = shift_enable;
    ratio_nxt    = pitch_ratio;
    fc_nxt       = fc;

    if (accept) begin
      target_nxt  = clamped;
      pend_en_nxt = req.req_enable;
      if (fade_req) state_nxt = FADE_OUT;
    end

    case (state)
      BYPASS: ratio_nxt = target;
      RUN: ;
      FADE_OUT: begin
        if (tick) begin
          fc_nxt = fc - 17'd1;
          if (fc == 17'd1) state_nxt = SWITCH;
        end
      end
      SWITCH: begin
        shift_en_nxt = pend_en;
        ratio_nxt    = target;
        state_nxt    = FADE_IN;
      end
      FADE_IN: begin
        if (tick) begin
          fc_nxt = fc + 17'd1;
          if (fc == FC_FULL - 17'd1) state_nxt = shift_enable ? RUN : BYPASS;
        end
      end
      default: state_nxt = BYPASS;
    endcase

`ifdef PITCH_RAMP_EN
    // A request landing mid-ramp retargets from wherever pitch_ratio currently is.
    if ((state == RUN) && (state_nxt == RUN) && tick) begin
      if (pitch_ratio < target_nxt)
        ratio_nxt = ((target_nxt - pitch_ratio) > RAMP_STEP) ? pitch_ratio + RAMP_STEP : target_nxt;
      else if (pitch_ratio > target_nxt)
        ratio_nxt = ((pitch_ratio - target_nxt) > RAMP_STEP) ? pitch_ratio - RAMP_STEP : target_nxt;
    end
`endif

    busy_nxt = (state_nxt == FADE_OUT) || (state_nxt == SWITCH) || (state_nxt == FADE_IN) ||
               (ratio_nxt != target_nxt);
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BYPASS;
      target       <= UNITY;
      pitch_ratio  <= UNITY;
      pend_en      <= 1'b0;
      shift_enable <= 1'b0;
      fc           <= FC_FULL;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      target       <= target_nxt;
      pitch_ratio  <= ratio_nxt;
      pend_en      <= pend_en_nxt;
      shift_enable <= shift_en_nxt;
      fc           <= fc_nxt;
      busy         <= busy_nxt;
    end
  end

  // Gain is below 1.0 whenever it is applied, so bits [47:16] always hold the whole result.
  logic signed [49:0] in_l_x, in_r_x, gain_x, prod_l, prod_r;
  logic signed [31:0] scaled_l, scaled_r;
  logic               unused_prod;

  assign gain     = fc << GAIN_SH;
  assign in_l_x   = {{18{in_L[31]}}, in_L};
  assign in_r_x   = {{18{in_R[31]}}, in_R};
  assign gain_x   = {33'd0, gain};
  assign prod_l   = in_l_x * gain_x;
  assign prod_r   = in_r_x * gain_x;
  assign scaled_l = (fc == FC_FULL) ? in_L : prod_l[47:16];
  assign scaled_r = (fc == FC_FULL) ? in_R : prod_r[47:16];
  assign unused_prod = ^{prod_l[49:48], prod_l[15:0], prod_r[49:48], prod_r[15:0]};

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      out_L <= '0;
      out_R <= '0;
    end else if (tick) begin
      out_L <= scaled_l;
      out_R <= scaled_r;
    end
  end

endmodule

// File: tb/tb_pitch_fx_sequencer.sv
// Directed bench for pitch_fx_sequencer with FADE_LEN=16; covers ramp or no-ramp build per PITCH_RAMP_EN.
module tb_pitch_fx_sequencer;

  logic               clk = 1'b0;
  logic               rst_n, tick;
  logic               shift_enable, busy;
  logic [15:0]        pitch_ratio;
  logic signed [31:0] in_L, in_R, out_L, out_R;
  int                 errors = 0;
  int                 checks = 0;

  always #5 clk = ~clk;

  pitch_fx_sequencer_if req_bus();

  pitch_fx_sequencer #(.FADE_LEN(16)) dut (
    .CLOCK_50     (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .req          (req_bus),
    .shift_enable (shift_enable),
    .pitch_ratio  (pitch_ratio),
    .busy         (busy),
    .in_L         (in_L),
    .in_R         (in_R),
    .out_L        (out_L),
    .out_R        (out_R)
  );

  typedef struct {
    logic [15:0] ratio;
    logic [15:0] exp_ratio;
    logic        exp_busy;
  } clamp_vec_t;

  typedef struct {
    logic [31:0] in_l;
    logic [31:0] in_r;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } fade_vec_t;

  clamp_vec_t clamp_tbl[8];
  fade_vec_t  fade_tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clk1(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic send(input logic [15:0] r, input logic en);
    chk("ready_before_req", {31'd0, req_bus.req_ready}, 32'd1);
    req_bus.req_valid  = 1'b1;
    req_bus.req_ratio  = r;
    req_bus.req_enable = en;
    @(posedge clk);
    #1;
    req_bus.req_valid = 1'b0;
  endtask

  initial begin
    clamp_tbl = '{
      '{16'h0800, 16'h0400, 1'b1},
      '{16'h0010, 16'h0040, 1'b1},
      '{16'h0200, 16'h0200, 1'b1},
      '{16'h003F, 16'h0040, 1'b1},
      '{16'h0401, 16'h0400, 1'b1},
      '{16'h0400, 16'h0400, 1'b0},
      '{16'h0040, 16'h0040, 1'b1},
      '{16'h0100, 16'h0100, 1'b1}
    };
    // Fade-out with FADE_LEN=16: tick k sees fc=17-k, gain=fc*4096.
    fade_tbl = '{
      '{32'h40000000, 32'hFFFFFFFD, 32'h40000000, 32'hFFFFFFFD},
      '{32'h40000000, 32'hFFFFFFFD, 32'h3C000000, 32'hFFFFFFFD},
      '{32'h40000000, 32'hFFFFFFFD, 32'h38000000, 32'hFFFFFFFD},
      '{32'h40000000, 32'hFFFFFFFD, 32'h34000000, 32'hFFFFFFFD},
      '{32'h40000000, 32'hFFFFFFFD, 32'h30000000, 32'hFFFFFFFD},
      '{32'h40000000, 32'hFFFFFFFD, 32'h2C000000, 32'hFFFFFFFD},
      '{32'h40000000, 32'hFFFFFFFD, 32'h28000000, 32'hFFFFFFFE},
      '{32'h40000000, 32'hFFFFFFFD, 32'h24000000, 32'hFFFFFFFE},
      '{32'h40000000, 32'hFFFFFFFD, 32'h20000000, 32'hFFFFFFFE},
      '{32'h40000000, 32'hFFFFFFFD, 32'h1C000000, 32'hFFFFFFFE},
      '{32'h40000000, 32'hFFFFFFFD, 32'h18000000, 32'hFFFFFFFE},
      '{32'h40000000, 32'hFFFFFFFD, 32'h14000000, 32'hFFFFFFFF},
      '{32'h40000000, 32'hFFFFFFFD, 32'h10000000, 32'hFFFFFFFF},
      '{32'h40000000, 32'hFFFFFFFD, 32'h0C000000, 32'hFFFFFFFF},
      '{32'h40000000, 32'hFFFFFFFD, 32'h08000000, 32'hFFFFFFFF},
      '{32'h40000000, 32'hFFFFFFFD, 32'h04000000, 32'hFFFFFFFF}
    };

    rst_n = 1'b0;
    tick  = 1'b0;
    in_L  = '0;
    in_R  = '0;
    req_bus.req_valid  = 1'b0;
    req_bus.req_ratio  = '0;
    req_bus.req_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("reset_pitch_ratio", {16'd0, pitch_ratio}, 32'h0100);
    chk("reset_shift_enable", {31'd0, shift_enable}, 32'd0);
    chk("reset_req_ready", {31'd0, req_bus.req_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_out_L", out_L, 32'd0);
    chk("reset_out_R", out_R, 32'd0);

    in_L = 32'h12345678;
    in_R = -32'sd7;
    clk1(1'b1);
    chk("unity_out_L", out_L, 32'h12345678);
    chk("unity_out_R", out_R, 32'hFFFFFFF9);
    in_L = 32'h0BADF00D;
    clk1(1'b0);
    chk("hold_out_L", out_L, 32'h12345678);

    foreach (clamp_tbl[i]) begin
      send(clamp_tbl[i].ratio, 1'b0);
      chk($sformatf("clamp%0d_busy", i), {31'd0, busy}, {31'd0, clamp_tbl[i].exp_busy});
      chk($sformatf("clamp%0d_ready", i), {31'd0, req_bus.req_ready}, 32'd1);
      clk1(1'b0);
      chk($sformatf("clamp%0d_ratio", i), {16'd0, pitch_ratio}, {16'd0, clamp_tbl[i].exp_ratio});
      chk($sformatf("clamp%0d_busy_after", i), {31'd0, busy}, 32'd0);
    end

    send(16'h0100, 1'b1);
    chk("fo_ready_drop", {31'd0, req_bus.req_ready}, 32'd0);
    chk("fo_busy", {31'd0, busy}, 32'd1);
    foreach (fade_tbl[i]) begin
      in_L = fade_tbl[i].in_l;
      in_R = fade_tbl[i].in_r;
      clk1(1'b1);
      chk($sformatf("fo%0d_out_L", i), out_L, fade_tbl[i].exp_l);
      chk($sformatf("fo%0d_out_R", i), out_R, fade_tbl[i].exp_r);
      chk($sformatf("fo%0d_shift_en", i), {31'd0, shift_enable}, 32'd0);
    end

    in_L = 32'h7FFFFFFF;
    in_R = -32'sd5;
    clk1(1'b1);
    chk("switch_out_L", out_L, 32'd0);
    chk("switch_out_R", out_R, 32'd0);
    chk("switch_shift_en", {31'd0, shift_enable}, 32'd1);
    chk("switch_ready", {31'd0, req_bus.req_ready}, 32'd0);

    in_L = 32'h40000000;
    for (int j = 1; j <= 16; j++) begin
      clk1(1'b1);
      chk($sformatf("fi%0d_out_L", j), out_L, 32'(j - 1) * 32'h04000000);
      if (j == 15) chk("fi15_ready", {31'd0, req_bus.req_ready}, 32'd0);
    end
    chk("run_ready", {31'd0, req_bus.req_ready}, 32'd1);
    chk("run_busy", {31'd0, busy}, 32'd0);
    chk("run_shift_en", {31'd0, shift_enable}, 32'd1);
    clk1(1'b1);
    chk("run_unity_out_L", out_L, 32'h40000000);

`ifdef PITCH_RAMP_EN
    send(16'h0125, 1'b1);
    chk("ramp_accept_ready", {31'd0, req_bus.req_ready}, 32'd1);
    chk("ramp_accept_busy", {31'd0, busy}, 32'd1);
    chk("ramp_accept_ratio", {16'd0, pitch_ratio}, 32'h0100);
    clk1(1'b1);
    chk("ramp1_ratio", {16'd0, pitch_ratio}, 32'h0110);
    chk("ramp1_busy", {31'd0, busy}, 32'd1);
    clk1(1'b1);
    chk("ramp2_ratio", {16'd0, pitch_ratio}, 32'h0120);
    chk("ramp2_busy", {31'd0, busy}, 32'd1);
    clk1(1'b1);
    chk("ramp3_ratio", {16'd0, pitch_ratio}, 32'h0125);
    chk("ramp3_busy", {31'd0, busy}, 32'd0);
    clk1(1'b1);
    chk("ramp4_hold", {16'd0, pitch_ratio}, 32'h0125);
    send(16'h00F0, 1'b1);
    clk1(1'b1);
    chk("ramp_down_ratio", {16'd0, pitch_ratio}, 32'h0115);
    send(16'h0200, 1'b1);
    chk("retarget_no_tick", {16'd0, pitch_ratio}, 32'h0115);
    clk1(1'b1);
    chk("retarget_ratio", {16'd0, pitch_ratio}, 32'h0125);
    chk("retarget_busy", {31'd0, busy}, 32'd1);
`else
    send(16'h0100, 1'b1);
    chk("same_ratio_ready", {31'd0, req_bus.req_ready}, 32'd1);
    chk("same_ratio_busy", {31'd0, busy}, 32'd0);
    send(16'h0200, 1'b1);
    chk("nr_ready_drop", {31'd0, req_bus.req_ready}, 32'd0);
    chk("nr_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      clk1(1'b1);
      chk($sformatf("nr_fo%0d_ratio", k), {16'd0, pitch_ratio}, 32'h0100);
      chk($sformatf("nr_fo%0d_shift_en", k), {31'd0, shift_enable}, 32'd1);
    end
    clk1(1'b0);
    chk("nr_switch_ratio", {16'd0, pitch_ratio}, 32'h0200);
    chk("nr_switch_shift_en", {31'd0, shift_enable}, 32'd1);
    for (int k = 0; k < 16; k++) clk1(1'b1);
    chk("nr_run_ready", {31'd0, req_bus.req_ready}, 32'd1);
    chk("nr_run_busy", {31'd0, busy}, 32'd0);
    chk("nr_run_ratio", {16'd0, pitch_ratio}, 32'h0200);
`endif

    send(16'h0100, 1'b0);
    in_L = 32'h40000000;
    repeat (11) clk1(1'b1);
    chk("pre_reset_out_L", out_L, 32'h18000000);
    chk("pre_reset_ready", {31'd0, req_bus.req_ready}, 32'd0);
    #1;
    rst_n = 1'b0;
    #2;
    chk("arst_pitch_ratio", {16'd0, pitch_ratio}, 32'h0100);
    chk("arst_shift_enable", {31'd0, shift_enable}, 32'd0);
    chk("arst_req_ready", {31'd0, req_bus.req_ready}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_out_L", out_L, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_L = 32'h23456789;
    repeat (3) begin
      clk1(1'b1);
      chk("post_reset_unity_out_L", out_L, 32'h23456789);
      chk("post_reset_ready", {31'd0, req_bus.req_ready}, 32'd1);
      chk("post_reset_busy", {31'd0, busy}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
